// File: rtl/semaphore_client.sv
// rtl/semaphore_client.sv - per-core semaphore initiator between execution unit and semaphore router
//
// Turns one core semaphore instruction into a one-cycle router strobe,
// waits a bounded window for ACK, retries with backoff, then pulses a
// pass/fail response back to the core.
//
// Ports:
//   CLK                               clock, rising edge
//   SEMAPHORECLIENT_RESETn            asynchronous active-low reset
//   SEMAPHORECLIENT_REQ_VALID/READY   instruction handshake (READY only in IDLE)
//   SEMAPHORECLIENT_REQ_OP/ADDR/DATA  00 none, 01 create, 10 release, 11 acquire
//   SEMAPHORECLIENT_RSP_VALID/OK/RETRIES  one-cycle response
//   SEMAPHORECLIENT_*_ToRouter        enable + op strobes, latched addr/data
//   SEMAPHORECLIENT_ACK_FromRouter    router acknowledge
module semaphore_client #(
  parameter int AckWindow     = 3,
  parameter int BackoffCycles = 2,
  parameter int MaxRetries    = 15
) (
  input  logic       CLK,
  input  logic       SEMAPHORECLIENT_RESETn,
  input  logic       SEMAPHORECLIENT_REQ_VALID,
  output logic       SEMAPHORECLIENT_REQ_READY,
  input  logic [1:0] SEMAPHORECLIENT_REQ_OP,
  input  logic [7:0] SEMAPHORECLIENT_REQ_ADDR,
  input  logic [3:0] SEMAPHORECLIENT_REQ_DATA,
  output logic       SEMAPHORECLIENT_RSP_VALID,
  output logic       SEMAPHORECLIENT_RSP_OK,
  output logic [3:0] SEMAPHORECLIENT_RSP_RETRIES,
  output logic       SEMAPHORECLIENT_EN_ToRouter,
  output logic       SEMAPHORECLIENT_CREATE_ToRouter,
  output logic       SEMAPHORECLIENT_RELEASE_ToRouter,
  output logic       SEMAPHORECLIENT_ACQUIRE_ToRouter,
  output logic [7:0] SEMAPHORECLIENT_Addr_ToRouter,
  output logic [3:0] SEMAPHORECLIENT_Data_ToRouter,
  input  logic       SEMAPHORECLIENT_ACK_FromRouter
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_BACKOFF,
    S_RESP
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [7:0] addr_q, addr_d;
  logic [3:0] data_q, data_d;
  logic [3:0] retry_q, retry_d;
  logic [7:0] cnt_q, cnt_d;   // shared by WAIT window and BACKOFF delay
  logic       ok_q, ok_d;

  always_ff @(posedge CLK or negedge SEMAPHORECLIENT_RESETn) begin
    if (!SEMAPHORECLIENT_RESETn) begin
      state_q <= S_IDLE;
      op_q    <= 2'd0;
      addr_q  <= 8'd0;
      data_q  <= 4'd0;
      retry_q <= 4'd0;
      cnt_q   <= 8'd0;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      retry_q <= retry_d;
      cnt_q   <= cnt_d;
      ok_q    <= ok_d;
    end
  end

  // Strobes decode from the state register only, so an asserted reset
  // drops them in the same instant without waiting for a clock.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    data_d  = data_q;
    retry_d = retry_q;
    cnt_d   = cnt_q;
    ok_d    = ok_q;

    SEMAPHORECLIENT_REQ_READY        = 1'b0;
    SEMAPHORECLIENT_RSP_VALID        = 1'b0;
    SEMAPHORECLIENT_RSP_OK           = 1'b0;
    SEMAPHORECLIENT_RSP_RETRIES      = 4'd0;
    SEMAPHORECLIENT_EN_ToRouter      = 1'b0;
    SEMAPHORECLIENT_CREATE_ToRouter  = 1'b0;
    SEMAPHORECLIENT_RELEASE_ToRouter = 1'b0;
    SEMAPHORECLIENT_ACQUIRE_ToRouter = 1'b0;

    case (state_q)
      S_IDLE: begin
        SEMAPHORECLIENT_REQ_READY = 1'b1;
        if (SEMAPHORECLIENT_REQ_VALID) begin
          retry_d = 4'd0;
          ok_d    = 1'b0;
          if (SEMAPHORECLIENT_REQ_OP != 2'b00) begin
            op_d    = SEMAPHORECLIENT_REQ_OP;
            addr_d  = SEMAPHORECLIENT_REQ_ADDR;
            data_d  = SEMAPHORECLIENT_REQ_DATA;
            state_d = S_ISSUE;
          end else begin
            // Null op: answer at once, router never sees it.
            state_d = S_RESP;
          end
        end
      end

      S_ISSUE: begin
        SEMAPHORECLIENT_EN_ToRouter      = 1'b1;
        SEMAPHORECLIENT_CREATE_ToRouter  = (op_q == 2'b01);
        SEMAPHORECLIENT_RELEASE_ToRouter = (op_q == 2'b10);
        SEMAPHORECLIENT_ACQUIRE_ToRouter = (op_q == 2'b11);
        cnt_d   = 8'd0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (SEMAPHORECLIENT_ACK_FromRouter) begin
          ok_d    = 1'b1;
          state_d = S_RESP;
        end else if (cnt_q == 8'(AckWindow - 1)) begin
          if (retry_q == 4'(MaxRetries)) begin
            ok_d    = 1'b0;
            state_d = S_RESP;
          end else begin
            retry_d = retry_q + 4'd1;
            cnt_d   = 8'd0;
            state_d = S_BACKOFF;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_BACKOFF: begin
        if (cnt_q == 8'(BackoffCycles - 1)) begin
          state_d = S_ISSUE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_RESP: begin
        SEMAPHORECLIENT_RSP_VALID   = 1'b1;
        SEMAPHORECLIENT_RSP_OK      = ok_q;
        SEMAPHORECLIENT_RSP_RETRIES = retry_q;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign SEMAPHORECLIENT_Addr_ToRouter = addr_q;
  assign SEMAPHORECLIENT_Data_ToRouter = data_q;

endmodule

// File: tb/tb_semaphore_client.sv
// tb/tb_semaphore_client.sv - directed self-checking bench for semaphore_client
module tb_semaphore_client;

  logic       CLK = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [7:0] req_addr;
  logic [3:0] req_data;
  logic       rsp_valid;
  logic       rsp_ok;
  logic [3:0] rsp_retries;
  logic       en_r, create_r, release_r, acquire_r;
  logic [7:0] addr_r;
  logic [3:0] data_r;
  logic       ack;

  int total = 0;
  int bad   = 0;
  int adj_err = 0;
  logic prev_en = 1'b0;

  semaphore_client dut (
    .CLK                              (CLK),
    .SEMAPHORECLIENT_RESETn           (rst_n),
    .SEMAPHORECLIENT_REQ_VALID        (req_valid),
    .SEMAPHORECLIENT_REQ_READY        (req_ready),
    .SEMAPHORECLIENT_REQ_OP           (req_op),
    .SEMAPHORECLIENT_REQ_ADDR         (req_addr),
    .SEMAPHORECLIENT_REQ_DATA         (req_data),
    .SEMAPHORECLIENT_RSP_VALID        (rsp_valid),
    .SEMAPHORECLIENT_RSP_OK           (rsp_ok),
    .SEMAPHORECLIENT_RSP_RETRIES      (rsp_retries),
    .SEMAPHORECLIENT_EN_ToRouter      (en_r),
    .SEMAPHORECLIENT_CREATE_ToRouter  (create_r),
    .SEMAPHORECLIENT_RELEASE_ToRouter (release_r),
    .SEMAPHORECLIENT_ACQUIRE_ToRouter (acquire_r),
    .SEMAPHORECLIENT_Addr_ToRouter    (addr_r),
    .SEMAPHORECLIENT_Data_ToRouter    (data_r),
    .SEMAPHORECLIENT_ACK_FromRouter   (ack)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Router modes: 0 never ACKs, 1 ACKs only attempt ack_on (2 cycles after
  // the strobe), 2 never ACKs in WAIT but pulses ACK during ISSUE/BACKOFF.
  task automatic run_txn(input logic [1:0] op, input logic [7:0] addr,
                         input logic [3:0] data, input int mode, input int ack_on,
                         output int rsp_cyc, output int ok, output int rt,
                         output int n_en, output int spacing_err,
                         output int strobe_err, output int addr_err);
    int k, cd, last_en;
    bit done;
    logic [2:0] exp_st;
    exp_st = (op == 2'b01) ? 3'b100 : (op == 2'b10) ? 3'b010 :
             (op == 2'b11) ? 3'b001 : 3'b000;
    rsp_cyc = -1; ok = -1; rt = -1; n_en = 0;
    spacing_err = 0; strobe_err = 0; addr_err = 0;
    cd = 0; last_en = 0; done = 1'b0;

    @(posedge CLK); #1;
    req_valid = 1'b1; req_op = op; req_addr = addr; req_data = data;
    @(negedge CLK);
    check("ready_before_accept", int'(req_ready), 1);
    if (prev_en && en_r) adj_err++;
    prev_en = en_r;
    @(posedge CLK); #1;
    req_valid = 1'b0; req_op = 2'b00; req_addr = 8'hFF; req_data = 4'hF;
    k = 0;
    while (!done && k < 200) begin
      if (mode == 2) begin
        ack = ((k % 6) == 0) || ((k % 6) == 4) || ((k % 6) == 5);
      end else begin
        ack = 1'b0;
        if (cd > 0) begin
          cd--;
          if (cd == 0) ack = 1'b1;
        end
      end
      @(negedge CLK);
      if (prev_en && en_r) adj_err++;
      prev_en = en_r;
      if ({create_r, release_r, acquire_r} !== (en_r ? exp_st : 3'b000)) strobe_err++;
      if (op != 2'b00 && (addr_r !== addr || data_r !== data)) addr_err++;
      if (en_r) begin
        n_en++;
        if (n_en > 1 && (k - last_en) != 6) spacing_err++;
        last_en = k;
        if (mode == 1 && n_en == ack_on) cd = 2;
      end
      if (rsp_valid) begin
        rsp_cyc = k + 1;
        ok = int'(rsp_ok);
        rt = int'(rsp_retries);
        done = 1'b1;
      end else begin
        @(posedge CLK); #1;
        k++;
      end
    end
    ack = 1'b0;
    if (!done) check("rsp_timeout", 0, 1);
  endtask

  int rc, okv, rtv, nen, sp, se, ae, cnt;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = 2'b00;
    req_addr = 8'h00; req_data = 4'h0; ack = 1'b0;
    #22;
    check("rst_ready",   int'(req_ready), 1);
    check("rst_rspv",    int'(rsp_valid), 0);
    check("rst_rspok",   int'(rsp_ok), 0);
    check("rst_retries", int'(rsp_retries), 0);
    check("rst_strobes", int'({en_r, create_r, release_r, acquire_r}), 0);
    check("rst_addr",    int'(addr_r), 0);
    check("rst_data",    int'(data_r), 0);
    @(negedge CLK); rst_n = 1'b1;

    // CREATE, ACK on first attempt
    run_txn(2'b01, 8'h05, 4'h3, 1, 1, rc, okv, rtv, nen, sp, se, ae);
    check("c_rsp_cycle", rc, 4);
    check("c_ok", okv, 1);
    check("c_retries", rtv, 0);
    check("c_en_pulses", nen, 1);
    check("c_strobe", se, 0);
    check("c_addr_hold", ae, 0);
    @(posedge CLK); #1;
    check("c_ready_after", int'(req_ready), 1);

    // ACQUIRE, router never ACKs: full retry budget
    run_txn(2'b11, 8'h02, 4'h0, 0, 0, rc, okv, rtv, nen, sp, se, ae);
    check("n_rsp_cycle", rc, 95);
    check("n_ok", okv, 0);
    check("n_retries", rtv, 15);
    check("n_en_pulses", nen, 16);
    check("n_spacing", sp, 0);
    check("n_strobe", se, 0);
    check("n_addr_hold", ae, 0);

    // ACQUIRE, ACK on third attempt
    run_txn(2'b11, 8'h02, 4'h0, 1, 3, rc, okv, rtv, nen, sp, se, ae);
    check("t_rsp_cycle", rc, 16);
    check("t_ok", okv, 1);
    check("t_retries", rtv, 2);
    check("t_en_pulses", nen, 3);
    check("t_strobe", se, 0);

    // Null op
    run_txn(2'b00, 8'h44, 4'h7, 1, 1, rc, okv, rtv, nen, sp, se, ae);
    check("z_rsp_cycle", rc, 1);
    check("z_ok", okv, 0);
    check("z_retries", rtv, 0);
    check("z_en_pulses", nen, 0);
    check("z_strobe", se, 0);

    // RELEASE aborted by reset in the second WAIT cycle
    @(posedge CLK); #1;
    req_valid = 1'b1; req_op = 2'b10; req_addr = 8'h01; req_data = 4'h0;
    @(negedge CLK);
    @(posedge CLK); #1;
    req_valid = 1'b0; req_op = 2'b00;
    @(posedge CLK); #1;
    @(posedge CLK); #2;
    rst_n = 1'b0;
    #1;
    check("r_strobes", int'({en_r, create_r, release_r, acquire_r}), 0);
    check("r_rspv", int'(rsp_valid), 0);
    check("r_ready", int'(req_ready), 1);
    @(negedge CLK); rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (rsp_valid || en_r) cnt++;
    end
    check("r_no_response", cnt, 0);
    prev_en = 1'b0;
    run_txn(2'b10, 8'h01, 4'h0, 1, 1, rc, okv, rtv, nen, sp, se, ae);
    check("r2_rsp_cycle", rc, 4);
    check("r2_ok", okv, 1);
    check("r2_retries", rtv, 0);

    // Stray ACKs during ISSUE and BACKOFF must be ignored
    run_txn(2'b11, 8'h09, 4'h0, 2, 0, rc, okv, rtv, nen, sp, se, ae);
    check("s_ok", okv, 0);
    check("s_retries", rtv, 15);
    check("s_en_pulses", nen, 16);
    check("s_rsp_cycle", rc, 95);

    // Back-to-back instruction immediately after a response
    run_txn(2'b01, 8'h0A, 4'h5, 1, 1, rc, okv, rtv, nen, sp, se, ae);
    check("b_ok", okv, 1);
    check("b_en_pulses", nen, 1);
    check("en_adjacent", adj_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
